// File: rtl/router_pkg.sv
// router_pkg
// Shared constants and helpers for the 5-port mesh router.
//   NUM_PORTS  : number of router input/output ports (E, W, N, S, inject/eject)
//   CODE_W     : width of an output-port request code
//   PORT_*     : output-port codes. The inject input also uses index PORT_EJECT.
//   ptr_inc()  : round-robin pointer increment, modulo NUM_PORTS
package router_pkg;

    localparam int NUM_PORTS = 5;
    localparam int CODE_W    = 3;

    typedef logic [CODE_W-1:0] port_code_t;

    localparam port_code_t PORT_E     = 3'd0;
    localparam port_code_t PORT_W     = 3'd1;
    localparam port_code_t PORT_N     = 3'd2;
    localparam port_code_t PORT_S     = 3'd3;
    localparam port_code_t PORT_EJECT = 3'd4;

    // Advance a port index by one, wrapping 4 -> 0. Out-of-range values
    // (5..7) also land on 0, which keeps a corrupted pointer self-healing.
    function automatic port_code_t ptr_inc(input port_code_t p);
        port_code_t r;
        if (p >= PORT_EJECT) begin
            r = PORT_E;
        end else begin
            r = p + 3'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arb5.sv
// rr_arb5
// Purely combinational 5-way round-robin arbiter.
//   i_req      : request vector, bit i = input i requesting
//   i_ptr      : highest-priority index (0..4)
//   o_gnt      : one-hot grant (all zero when nothing requests)
//   o_gnt_v    : at least one grant issued
//   o_ptr_nxt  : pointer to load when granting (winner + 1 mod 5);
//                equals the sanitised i_ptr when nothing is granted
module rr_arb5
    import router_pkg::*;
(
    input  logic [4:0] i_req,
    input  logic [2:0] i_ptr,
    output logic [4:0] o_gnt,
    output logic       o_gnt_v,
    output logic [2:0] o_ptr_nxt
);

    logic [2:0] w_ptr_safe;
    logic [2:0] w_idx;
    logic       w_found;

    // Clamp an illegal pointer value to 0 so the scan always covers 0..4.
    always_comb begin
        if (i_ptr > PORT_EJECT) begin
            w_ptr_safe = PORT_E;
        end else begin
            w_ptr_safe = i_ptr;
        end
    end

    // Scan from the pointer upward, wrapping, and grant the first requester.
    always_comb begin
        o_gnt     = 5'b00000;
        o_gnt_v   = 1'b0;
        o_ptr_nxt = w_ptr_safe;
        w_found   = 1'b0;
        w_idx     = w_ptr_safe;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!w_found && i_req[w_idx]) begin
                w_found        = 1'b1;
                o_gnt[w_idx]   = 1'b1;
                o_gnt_v        = 1'b1;
                o_ptr_nxt      = ptr_inc(w_idx);
            end else begin
                w_found = w_found;
            end
            w_idx = ptr_inc(w_idx);
        end
    end

endmodule

// File: rtl/switch_alloc_rr.sv
// switch_alloc_rr
// Separable round-robin switch allocator for the 5-port mesh router.
// Each output port runs its own round-robin arbiter over the inputs that
// request it; since every input names exactly one output, each input wins
// at most one output and the per-input grant is a simple OR.
//   clk, reset        : router clock, synchronous active-high reset
//   *_v               : per-input head-flit valid (E, W, N, S, inject)
//   *_req             : per-input requested output code (0..4; 5..7 never match)
//   out_full          : per-output downstream full, bit index = output code
//   *_g               : registered per-input grants, valid for one cycle
//   out_busy          : registered per-output "granted this cycle"
module switch_alloc_rr
    import router_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       e_v,
    input  logic       w_v,
    input  logic       n_v,
    input  logic       s_v,
    input  logic       inject_v,
    input  logic [2:0] e_req,
    input  logic [2:0] w_req,
    input  logic [2:0] n_req,
    input  logic [2:0] s_req,
    input  logic [2:0] inject_req,
    input  logic [4:0] out_full,
    output logic       e_g,
    output logic       w_g,
    output logic       n_g,
    output logic       s_g,
    output logic       inject_g,
    output logic [4:0] out_busy
);

    logic [4:0] w_valid;
    logic [2:0] w_code      [NUM_PORTS];
    logic [4:0] w_req_vec   [NUM_PORTS];
    logic [4:0] w_arb_gnt   [NUM_PORTS];
    logic       w_arb_v     [NUM_PORTS];
    logic [2:0] w_arb_ptr   [NUM_PORTS];
    logic [4:0] w_in_gnt;
    logic [4:0] w_busy;

    logic [2:0] r_ptr       [NUM_PORTS];
    logic [4:0] r_gnt;
    logic [4:0] r_busy;

    assign w_valid   = {inject_v, s_v, n_v, w_v, e_v};
    assign w_code[0] = e_req;
    assign w_code[1] = w_req;
    assign w_code[2] = n_req;
    assign w_code[3] = s_req;
    assign w_code[4] = inject_req;

    // Per-output request vectors; a full output sees no requests at all.
    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            w_req_vec[o] = 5'b00000;
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                w_req_vec[o][i] = w_valid[i] && (w_code[i] == 3'(o)) && !out_full[o];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_PORTS; g++) begin : g_arb
            rr_arb5 u_arb (
                .i_req     (w_req_vec[g]),
                .i_ptr     (r_ptr[g]),
                .o_gnt     (w_arb_gnt[g]),
                .o_gnt_v   (w_arb_v[g]),
                .o_ptr_nxt (w_arb_ptr[g])
            );
        end
    endgenerate

    // Fold per-output grants into per-input grants and per-output busy flags.
    always_comb begin
        w_in_gnt = 5'b00000;
        w_busy   = 5'b00000;
        for (int o = 0; o < NUM_PORTS; o++) begin
            w_in_gnt  = w_in_gnt | w_arb_gnt[o];
            w_busy[o] = w_arb_v[o];
        end
    end

    // Grant/busy registers and round-robin pointers; pointers move only on a grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt  <= 5'b00000;
            r_busy <= 5'b00000;
            for (int o = 0; o < NUM_PORTS; o++) begin
                r_ptr[o] <= 3'd0;
            end
        end else begin
            r_gnt  <= w_in_gnt;
            r_busy <= w_busy;
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (w_arb_v[o]) begin
                    r_ptr[o] <= w_arb_ptr[o];
                end else begin
                    r_ptr[o] <= r_ptr[o];
                end
            end
        end
    end

    assign e_g      = r_gnt[0];
    assign w_g      = r_gnt[1];
    assign n_g      = r_gnt[2];
    assign s_g      = r_gnt[3];
    assign inject_g = r_gnt[4];
    assign out_busy = r_busy;

endmodule

// File: doc/switch_alloc_rr.md
Name: switch_alloc_rr

Overview:
- Separable round-robin switch allocator for the 5-port mesh router.
- Sits directly upstream of the crossbar select generator.
- Takes each input port's requested output-port code plus a valid flag and resolves contention per output port.
- Emits the registered per-input grants (e_g, w_g, n_g, s_g, inject_g) that the select generator consumes alongside the unchanged request codes.

Parameters:
- NUM_PORTS, 5, number of input/output ports (fixed at 5; order E=0, W=1, N=2, S=3, inject/eject=4)
- CODE_W, 3, width of the output-port request code

Ports:
- clk  input  1  router clock
- reset  input  1  synchronous, active-high reset
- e_v  input  1  east input has a head flit requesting
- w_v  input  1  west input valid
- n_v  input  1  north input valid
- s_v  input  1  south input valid
- inject_v  input  1  local inject input valid
- e_req  input  3  east input requested output code (0=E, 1=W, 2=N, 3=S, 4=eject)
- w_req  input  3  west requested output code
- n_req  input  3  north requested output code
- s_req  input  3  south requested output code
- inject_req  input  3  inject requested output code
- out_full  input  5  per-output downstream full/no-credit, bit index = output code
- e_g  output  1  east input granted (registered)
- w_g  output  1  west input granted
- n_g  output  1  north input granted
- s_g  output  1  south input granted
- inject_g  output  1  inject input granted
- out_busy  output  5  per-output "granted this cycle", bit index = output code (registered)

Behaviour:
- Reset (sampled at posedge clk while reset=1): all grants and out_busy go to 0, all five round-robin pointers go to 0. A reset asserted mid-operation clears the next-cycle grants regardless of requests.
- Request vector per output o: bit i is set iff input i is valid, input i's req == o, and out_full[o] == 0.
- Invalid request codes 5..7 never match any output, so the input is never granted; this is not an error.
- Arbitration per output o:
  - pointer ptr[o] is 0..4.
  - The winner is the first set bit scanning i = ptr[o], ptr[o]+1, ... mod 5.
- Each input requests exactly one output code, so each input wins at most one output and grants are naturally one-hot per output.
- Latency: requests sampled at edge k produce grants visible after edge k (registered), held for exactly one cycle. The select generator registers the selects one cycle later.
- Pointer update at the same edge:
  - When output o grants input w, ptr[o] <= (w+1) mod 5, with wrap from 4 to 0.
  - Otherwise ptr[o] holds. Pointers of un-granted outputs never move.
- out_full[o]=1 masks all requests to o: no grant, pointer holds.
- A grant does not depend on the previous cycle's grant. A requester that keeps requesting is re-arbitrated every cycle, and fairness follows from the pointer.
- Simultaneous events:
  - All 5 inputs requesting the same output are served in rotation, each exactly once per 5 granted cycles.
  - Disjoint requests are all granted in the same cycle.

Decomposition:
- Shared package router_pkg holds:
  - constants PORT_E=3'd0, PORT_W=3'd1, PORT_N=3'd2, PORT_S=3'd3, PORT_EJECT=3'd4 (inject input also index 4);
  - NUM_PORTS=5;
  - CODE_W=3.
- One sub-module, rr_arb5, is natural and is instantiated 5 times:
  - inputs: 5-bit request vector and 3-bit pointer;
  - outputs: 5-bit one-hot grant, a grant-valid flag, and the 3-bit next pointer;
  - purely combinational.
- Top level builds the request vectors, ORs the per-output grants into per-input grants, and owns all registers.

Test Plan:
- Reset: drive reset=1 with all inputs valid -> after the edge all *_g=0, out_busy=0; after release, first arbitration uses ptr=0.
- Disjoint: e_req=1, w_req=0, n_req=3, s_req=2, inject_req=4, all valid -> next cycle all five grants=1, out_busy=5'b11111.
- Contention rotation: all five valid, req=4 (eject), held 6 cycles -> grants rotate E, W, N, S, inject, E. ptr[4] sequence is 1, 2, 3, 4, 0, 1.
- Backpressure: e_v=w_v=1, both req=2, out_full=5'b00100 for 3 cycles, then 0 -> no grants while full and ptr[2] unchanged. First grant after release goes to E, the next to W.
- Invalid code: n_v=1, n_req=7, other inputs idle -> n_g stays 0, out_busy=0, all pointers unchanged.
- Mid-operation reset: run rotation to ptr[4]=3, assert reset one cycle with requests held -> grants 0 that cycle; next arbitration grants E (ptr reset to 0).
